// File: rtl/dram_training_seq.sv
// rtl/dram_training_seq.sv - DRAM training step sequencer between the APB start/done bits and the PHY training engine
// Runs single steps or the full ZQ..WR_DQ chain through a req/ack/done handshake, with timeout supervision.
module dram_training_seq #(
   parameter int TIMEOUT = 4096,
   parameter int STEP_W  = 3
) (
   input  logic              pclk_i,
   input  logic              prst_i,
   input  logic              zq_training_start_i,
   input  logic              ca_training_start_i,
   input  logic              wr_lvl_training_start_i,
   input  logic              rd_gate_training_start_i,
   input  logic              rd_lvl_training_start_i,
   input  logic              wr_dq_training_start_i,
   input  logic              all_training_start_i,
   output logic              zq_training_done_o,
   output logic              ca_training_done_o,
   output logic              wr_lvl_training_done_o,
   output logic              rd_gate_training_done_o,
   output logic              rd_lvl_training_done_o,
   output logic              wr_dq_training_done_o,
   output logic              all_training_done_o,
   output logic              eng_req_o,
   output logic [STEP_W-1:0] eng_step_o,
   input  logic              eng_ack_i,
   input  logic              eng_done_i,
   input  logic              eng_fail_i,
   output logic              busy_o,
   output logic              fail_o,
   output logic [STEP_W-1:0] fail_step_o
);

   localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(5);
   localparam int               ALL        = 6;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [STEP_W-1:0] fail_step_q, fail_step_d;
   logic [6:0]        done_q, done_d;
   logic [6:0]        start_prev_q;
   logic [6:0]        start_vec, start_edge;
   logic              all_mode_q, all_mode_d;
   logic              fail_q, fail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_hit;
   logic              step_fail;

   // Bit index doubles as the engine step code for bits 0..5.
   assign start_vec   = {all_training_start_i, wr_dq_training_start_i, rd_lvl_training_start_i,
                         rd_gate_training_start_i, wr_lvl_training_start_i, ca_training_start_i,
                         zq_training_start_i};
   assign start_edge  = start_vec & ~start_prev_q;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      all_mode_d  = all_mode_q;
      done_d      = done_q;
      fail_d      = fail_q;
      fail_step_d = fail_step_q;
      step_fail   = 1'b0;
      cnt_d       = (state_q == S_IDLE || cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_edge != '0) begin
               state_d     = S_REQ;
               cnt_d       = '0;
               fail_d      = 1'b0;
               fail_step_d = '0;
               if (start_edge[ALL]) begin
                  all_mode_d = 1'b1;
                  step_d     = '0;
                  done_d     = '0;
               end else begin
                  all_mode_d = 1'b0;
                  // Descending scan so the lowest-numbered edge wins.
                  for (int i = 5; i >= 0; i--) begin
                     if (start_edge[i]) step_d = STEP_W'(i);
                  end
                  done_d[step_d] = 1'b0;
               end
            end
         end
         S_REQ: begin
            if (timeout_hit) step_fail = 1'b1;
            else if (eng_ack_i) state_d = S_RUN;
         end
         S_RUN: begin
            if (eng_fail_i || (timeout_hit && !eng_done_i)) begin
               step_fail = 1'b1;
            end else if (eng_done_i) begin
               done_d[step_q] = 1'b1;
               if (all_mode_q && step_q != STEP_LAST) begin
                  step_d  = step_q + 1'b1;
                  state_d = S_REQ;
                  cnt_d   = '0;
               end else begin
                  if (all_mode_q) done_d[ALL] = 1'b1;
                  state_d    = S_IDLE;
                  step_d     = '0;
                  all_mode_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (step_fail) begin
         fail_d      = 1'b1;
         fail_step_d = step_q;
         state_d     = S_IDLE;
         step_d      = '0;
         all_mode_d  = 1'b0;
      end
   end

   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         state_q      <= S_IDLE;
         step_q       <= '0;
         all_mode_q   <= 1'b0;
         done_q       <= '0;
         fail_q       <= 1'b0;
         fail_step_q  <= '0;
         cnt_q        <= '0;
         start_prev_q <= '0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         all_mode_q   <= all_mode_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         fail_step_q  <= fail_step_d;
         cnt_q        <= cnt_d;
         start_prev_q <= start_vec;
      end
   end

   assign eng_req_o               = (state_q == S_REQ);
   assign eng_step_o              = step_q;
   assign busy_o                  = (state_q != S_IDLE);
   assign fail_o                  = fail_q;
   assign fail_step_o             = fail_step_q;
   assign zq_training_done_o      = done_q[0];
   assign ca_training_done_o      = done_q[1];
   assign wr_lvl_training_done_o  = done_q[2];
   assign rd_gate_training_done_o = done_q[3];
   assign rd_lvl_training_done_o  = done_q[4];
   assign wr_dq_training_done_o   = done_q[5];
   assign all_training_done_o     = done_q[6];

endmodule

// File: tb/tb_dram_training_seq.sv
// tb/tb_dram_training_seq.sv - directed self-checking bench for dram_training_seq
module tb_dram_training_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] start;
   wire  [6:0] done_v;
   logic       eng_ack_i, eng_done_i, eng_fail_i;
   wire        eng_req_o, busy_o, fail_o;
   wire  [2:0] eng_step_o, fail_step_o;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   dram_training_seq #(.TIMEOUT(16), .STEP_W(3)) dut (
      .pclk_i                  (clk),
      .prst_i                  (rst),
      .zq_training_start_i     (start[0]),
      .ca_training_start_i     (start[1]),
      .wr_lvl_training_start_i (start[2]),
      .rd_gate_training_start_i(start[3]),
      .rd_lvl_training_start_i (start[4]),
      .wr_dq_training_start_i  (start[5]),
      .all_training_start_i    (start[6]),
      .zq_training_done_o      (done_v[0]),
      .ca_training_done_o      (done_v[1]),
      .wr_lvl_training_done_o  (done_v[2]),
      .rd_gate_training_done_o (done_v[3]),
      .rd_lvl_training_done_o  (done_v[4]),
      .wr_dq_training_done_o   (done_v[5]),
      .all_training_done_o     (done_v[6]),
      .eng_req_o               (eng_req_o),
      .eng_step_o              (eng_step_o),
      .eng_ack_i               (eng_ack_i),
      .eng_done_i              (eng_done_i),
      .eng_fail_i              (eng_fail_i),
      .busy_o                  (busy_o),
      .fail_o                  (fail_o),
      .fail_step_o             (fail_step_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // resp: 0 = done, 1 = fail, 2 = done and fail together; 5 cycles per step
   task automatic do_step(input int s, input int resp);
      check("step_req", eng_req_o, 1);
      check("step_code", eng_step_o, s);
      eng_ack_i = 1'b1;
      tick();
      eng_ack_i = 1'b0;
      check("step_run_req", eng_req_o, 0);
      check("step_run_busy", busy_o, 1);
      tick(3);
      eng_done_i = (resp != 1);
      eng_fail_i = (resp != 0);
      tick();
      eng_done_i = 1'b0;
      eng_fail_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = '0; eng_ack_i = 1'b0; eng_done_i = 1'b0; eng_fail_i = 1'b0;
      tick(2);
      check("rst_done", done_v, 0);
      check("rst_req", eng_req_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_fail", fail_o, 0);
      check("rst_step", eng_step_o, 0);
      rst = 1'b0;
      tick();

      // 1: single ZQ, ack two cycles after start, done ten cycles after ack
      start = 7'h01;
      tick();
      start = '0;
      check("t1_req", eng_req_o, 1);
      check("t1_busy", busy_o, 1);
      check("t1_step", eng_step_o, 0);
      tick();
      check("t1_req_hold", eng_req_o, 1);
      eng_ack_i = 1'b1;
      tick();
      eng_ack_i = 1'b0;
      check("t1_req_drop", eng_req_o, 0);
      check("t1_run_busy", busy_o, 1);
      tick(9);
      eng_done_i = 1'b1;
      check("t1_pre_done", done_v, 0);
      tick();
      eng_done_i = 1'b0;
      check("t1_done", done_v, 7'h01);
      check("t1_idle", busy_o, 0);

      // 2: full chain, next REQ right after each done
      start = 7'h40;
      tick();
      start = '0;
      check("t2_cleared", done_v, 0);
      for (int s = 0; s < 6; s++) begin
         check("t2_all_pre", done_v[6], 0);
         do_step(s, 0);
         check("t2_bit", done_v[s], 1);
      end
      check("t2_done", done_v, 7'h7f);
      check("t2_idle", busy_o, 0);
      check("t2_step_idle", eng_step_o, 0);

      // 3: fail on WR_LVL skips the rest
      start = 7'h40;
      tick();
      start = '0;
      check("t3_cleared", done_v, 0);
      do_step(0, 0);
      do_step(1, 0);
      do_step(2, 1);
      check("t3_fail", fail_o, 1);
      check("t3_fail_step", fail_step_o, 2);
      check("t3_done", done_v, 7'h03);
      check("t3_idle", busy_o, 0);
      tick(3);
      check("t3_no_req", eng_req_o, 0);
      check("t3_no_busy", busy_o, 0);

      // 4: timeout on CA after 16 cycles in REQ/RUN
      start = 7'h02;
      tick();
      start = '0;
      check("t4_ca_clr", done_v, 7'h01);
      check("t4_fail_clr", fail_o, 0);
      eng_ack_i = 1'b1;
      tick();
      eng_ack_i = 1'b0;
      tick(14);
      check("t4_pre_to", fail_o, 0);
      check("t4_pre_busy", busy_o, 1);
      tick();
      check("t4_to_fail", fail_o, 1);
      check("t4_to_step", fail_step_o, 1);
      check("t4_to_idle", busy_o, 0);
      start = 7'h02;
      tick();
      start = '0;
      check("t4_refail_clr", fail_o, 0);
      check("t4_restep_clr", fail_step_o, 0);
      do_step(1, 0);
      check("t4_ca_ok", done_v, 7'h03);
      start = 7'h02;
      tick();
      start = '0;
      check("t4_ca_reclr", done_v, 7'h01);
      do_step(1, 0);
      check("t4_ca_ok2", done_v, 7'h03);

      // 5: priority, ignored edge while busy, held level
      start = 7'h12;
      tick();
      start = '0;
      check("t5_req", eng_req_o, 1);
      check("t5_prio", eng_step_o, 1);
      eng_ack_i = 1'b1;
      tick();
      eng_ack_i = 1'b0;
      start = 7'h20;
      tick();
      start = '0;
      tick();
      check("t5_still_ca", eng_step_o, 1);
      eng_done_i = 1'b1;
      tick();
      eng_done_i = 1'b0;
      check("t5_done", done_v, 7'h03);
      check("t5_idle", busy_o, 0);
      tick();
      check("t5_no_queue", busy_o, 0);
      start = 7'h01;
      tick();
      check("t5_zq_clr", done_v, 7'h02);
      do_step(0, 0);
      check("t5_zq_done", done_v, 7'h03);
      tick(3);
      check("t5_held_busy", busy_o, 0);
      check("t5_held_req", eng_req_o, 0);
      start = '0;

      // 6: done+fail together, then reset during RUN
      start = 7'h08;
      tick();
      start = '0;
      do_step(3, 2);
      check("t6_fail", fail_o, 1);
      check("t6_fail_step", fail_step_o, 3);
      check("t6_done", done_v, 7'h03);
      start = 7'h04;
      tick();
      start = '0;
      eng_ack_i = 1'b1;
      tick();
      eng_ack_i = 1'b0;
      check("t6_run", busy_o, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_req", eng_req_o, 0);
      check("t6_rst_busy", busy_o, 0);
      check("t6_rst_done", done_v, 0);
      check("t6_rst_fail", fail_o, 0);
      check("t6_rst_step", eng_step_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
